// File: rtl/uart_pkg.sv
//------------------------------------------------------------------------------
// Package : uart_pkg
// Shared types and the wrap-around priority search for the UART channel selector.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

    localparam int UART_DATA_W  = 8;
    localparam int RR_MAX_CH    = 32;
    localparam int RR_IDX_W     = $clog2(RR_MAX_CH);

    typedef enum logic [0:0] {
        MODE_LEGACY = 1'b0,
        MODE_RR     = 1'b1
    } sel_mode_t;

    typedef struct packed {
        logic                hit;
        logic [RR_IDX_W-1:0] idx;
    } rr_pick_t;

    // First set bit of valid, scanning upward from ptr+1 and wrapping at num_ch.
    // The scan walks offsets from far to near so the nearest hit is written last.
    function automatic rr_pick_t rr_pick(input logic [RR_MAX_CH-1:0] valid,
                                         input int ptr,
                                         input int num_ch);
        rr_pick_t r;
        int       k;
        r = '0;
        for (int i = RR_MAX_CH; i >= 1; i--) begin
            if (i <= num_ch) begin
                k = ptr + i;
                if (k >= num_ch) k = k - num_ch;
                if (valid[k]) begin
                    r.hit = 1'b1;
                    r.idx = RR_IDX_W'(k);
                end
            end
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_skid_fifo2.sv
//------------------------------------------------------------------------------
// Module  : uart_skid_fifo2
// Two-entry in-order buffer with push/pop handshake and occupancy count.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_skid_fifo2 #(
    parameter int W = 8
) (
    input  logic         m_clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic         head_valid,
    output logic [1:0]   count
);

    logic [W-1:0] r_head;
    logic [W-1:0] r_tail;
    logic [1:0]   r_count;

    // Callers never push when full nor pop when empty, so only the legal
    // transitions are decoded; the head is held untouched when it drains.
    always_ff @(posedge m_clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 2'd0;
        end else if (push && pop) begin
            if (r_count == 2'd1) begin
                r_head <= push_data;
            end else begin
                r_head <= r_tail;
                r_tail <= push_data;
            end
        end else if (push) begin
            if (r_count == 2'd0) r_head <= push_data;
            else                 r_tail <= push_data;
            r_count <= r_count + 2'd1;
        end else if (pop) begin
            if (r_count == 2'd2) r_head <= r_tail;
            r_count <= r_count - 2'd1;
        end
    end

    assign head_data  = r_head;
    assign head_valid = (r_count != 2'd0);
    assign count      = r_count;

endmodule

`default_nettype wire

// File: rtl/uart_chan_select.sv
//------------------------------------------------------------------------------
// Module  : uart_chan_select
// N-channel byte selector (legacy fixed select or round-robin) into a 2-entry buffer.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_chan_select
    import uart_pkg::*;
#(
    parameter  int DATA_W = UART_DATA_W,
    parameter  int NUM_CH = 2,
    localparam int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                     m_clk,
    input  logic                     reset,
    input  logic                     fifo_en,
    input  logic                     dma_mode,
    input  logic                     rr_en,
    input  logic [SEL_W-1:0]         fixed_sel,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic [NUM_CH-1:0]        in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_ch,
    input  logic                     out_ready,
    output logic [1:0]               occupancy
);

    localparam int c_ENTRY_W = DATA_W + SEL_W;

    sel_mode_t              w_mode;
    logic [RR_MAX_CH-1:0]   w_valid_ext;
    rr_pick_t               w_pick;
    logic [SEL_W-1:0]       w_gnt;
    logic                   w_gnt_hit;
    logic [NUM_CH-1:0]      w_ready;
    logic                   w_push;
    logic                   w_pop;
    logic [c_ENTRY_W-1:0]   w_push_entry;
    logic [c_ENTRY_W-1:0]   w_head;
    logic                   w_head_valid;
    logic [1:0]             w_count;
    logic [SEL_W-1:0]       r_rr_ptr;

    assign w_mode = rr_en ? MODE_RR : MODE_LEGACY;

    always_comb begin
        w_valid_ext             = '0;
        w_valid_ext[NUM_CH-1:0] = in_valid;
        w_pick                  = rr_pick(w_valid_ext, int'(r_rr_ptr), NUM_CH);
    end

    // Legacy mode always names a channel, even one with nothing to send.
    always_comb begin
        w_gnt     = '0;
        w_gnt_hit = 1'b0;
        case (w_mode)
            MODE_RR: begin
                w_gnt_hit = w_pick.hit;
                w_gnt     = SEL_W'(w_pick.idx);
            end
            default: begin
                w_gnt_hit = 1'b1;
                if (fifo_en && dma_mode && (int'(fixed_sel) < NUM_CH))
                    w_gnt = fixed_sel;
            end
        endcase
    end

    always_comb begin
        w_ready = '0;
        if (w_gnt_hit && !reset && (w_count != 2'd2))
            w_ready[w_gnt] = 1'b1;
    end

    assign in_ready     = w_ready;
    assign w_push       = |(in_valid & w_ready);
    assign w_pop        = w_head_valid & out_ready;
    assign w_push_entry = {in_data[int'(w_gnt)*DATA_W +: DATA_W], w_gnt};

    always_ff @(posedge m_clk) begin
        if (reset)
            r_rr_ptr <= SEL_W'(NUM_CH - 1);
        else if (w_push && (w_mode == MODE_RR))
            r_rr_ptr <= w_gnt;
    end

    uart_skid_fifo2 #(
        .W (c_ENTRY_W)
    ) u_fifo (
        .m_clk      (m_clk),
        .reset      (reset),
        .push       (w_push),
        .push_data  (w_push_entry),
        .pop        (w_pop),
        .head_data  (w_head),
        .head_valid (w_head_valid),
        .count      (w_count)
    );

    assign out_valid = w_head_valid;
    assign out_data  = w_head[c_ENTRY_W-1:SEL_W];
    assign out_ch    = w_head[SEL_W-1:0];
    assign occupancy = w_count;

endmodule

`default_nettype wire

// File: tb/tb_uart_chan_select.sv
//------------------------------------------------------------------------------
// Module  : tb_uart_chan_select
// Directed bench for uart_chan_select with a 2-channel and a 4-channel instance.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_uart_chan_select;

    logic m_clk;
    logic reset;

    // 2-channel instance
    logic        fifo_en2, dma_mode2, rr_en2, out_ready2, out_valid2;
    logic [0:0]  fixed_sel2, out_ch2;
    logic [1:0]  in_valid2, in_ready2, occupancy2;
    logic [15:0] in_data2;
    logic [7:0]  out_data2;

    // 4-channel instance
    logic        fifo_en4, dma_mode4, rr_en4, out_ready4, out_valid4;
    logic [1:0]  fixed_sel4, out_ch4, occupancy4;
    logic [3:0]  in_valid4, in_ready4;
    logic [31:0] in_data4;
    logic [7:0]  out_data4;

    int n_vec;
    int n_err;

    uart_chan_select #(.DATA_W(8), .NUM_CH(2)) u_dut2 (
        .m_clk(m_clk), .reset(reset), .fifo_en(fifo_en2), .dma_mode(dma_mode2),
        .rr_en(rr_en2), .fixed_sel(fixed_sel2), .in_valid(in_valid2), .in_data(in_data2),
        .in_ready(in_ready2), .out_valid(out_valid2), .out_data(out_data2), .out_ch(out_ch2),
        .out_ready(out_ready2), .occupancy(occupancy2)
    );

    uart_chan_select #(.DATA_W(8), .NUM_CH(4)) u_dut4 (
        .m_clk(m_clk), .reset(reset), .fifo_en(fifo_en4), .dma_mode(dma_mode4),
        .rr_en(rr_en4), .fixed_sel(fixed_sel4), .in_valid(in_valid4), .in_data(in_data4),
        .in_ready(in_ready4), .out_valid(out_valid4), .out_data(out_data4), .out_ch(out_ch4),
        .out_ready(out_ready4), .occupancy(occupancy4)
    );

    initial m_clk = 1'b0;
    always #5 m_clk = ~m_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge m_clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        {fifo_en2, dma_mode2, rr_en2, out_ready2, fixed_sel2} = '0;
        in_valid2 = 2'b00; in_data2 = 16'h2211;
        {fifo_en4, dma_mode4, rr_en4, fixed_sel4} = '0;
        rr_en4 = 1'b1; out_ready4 = 1'b1;
        in_valid4 = 4'b1111; in_data4 = 32'hC3C2C1C0;

        // Reset: outputs cleared, ready suppressed even with every channel valid.
        step();
        step();
        #1;
        check_eq("rst_in_ready4",  in_ready4,  4'b0000);
        check_eq("rst_out_valid4", out_valid4, 1'b0);
        check_eq("rst_occ4",       occupancy4, 2'd0);
        check_eq("rst_out_data4",  out_data4,  8'h00);
        check_eq("rst_out_ch4",    out_ch4,    2'd0);
        check_eq("rst_out_valid2", out_valid2, 1'b0);

        // Release; 4-ch round-robin runs while 2-ch legacy is exercised.
        reset = 1'b0;
        fifo_en2 = 1'b1; dma_mode2 = 1'b0; in_valid2 = 2'b11; out_ready2 = 1'b1;
        #1;
        check_eq("leg_ready_sel0", in_ready2, 2'b01);
        for (int i = 0; i < 8; i++) begin
            check_eq("rr_ready_onehot", in_ready4, 4'b0001 << (i % 4));
            step();
            check_eq("rr_out_ch",   out_ch4,   i % 4);
            check_eq("rr_out_data", out_data4, 8'hC0 + (i % 4));
            if (i == 0) begin
                check_eq("leg_out_data0", out_data2, 8'h11);
                check_eq("leg_out_ch0",   out_ch2,   1'b0);
                fifo_en2 = 1'b1; dma_mode2 = 1'b1; fixed_sel2 = 1'b1;
            end
            if (i == 1) begin
                check_eq("leg_out_data1", out_data2, 8'h22);
                check_eq("leg_out_ch1",   out_ch2,   1'b1);
                check_eq("leg_occ1",      occupancy2, 2'd1);
                in_valid2 = 2'b00;
            end
            #1;
            if (i == 0) check_eq("leg_ready_sel1", in_ready2, 2'b10);
        end
        in_valid4 = 4'b0000;
        step();
        check_eq("rr_drain_occ", occupancy4, 2'd0);
        check_eq("leg2_drain_occ", occupancy2, 2'd0);

        // Backpressure: ch0 streams A0, A1, A2 with the consumer stalled.
        out_ready4 = 1'b0; in_valid4 = 4'b0001; in_data4 = 32'h000000A0;
        step();
        check_eq("bp_occ_a", occupancy4, 2'd1);
        in_data4 = 32'h000000A1;
        step();
        check_eq("bp_occ_b", occupancy4, 2'd2);
        in_data4 = 32'h000000A2;
        #1;
        check_eq("bp_ready_full", in_ready4, 4'b0000);
        step();
        check_eq("bp_occ_c",  occupancy4, 2'd2);
        check_eq("bp_hold",   out_data4,  8'hA0);
        out_ready4 = 1'b1;
        step();
        check_eq("bp_pop1",   out_data4,  8'hA1);
        check_eq("bp_occ_d",  occupancy4, 2'd1);
        check_eq("bp_ready",  in_ready4,  4'b0001);
        step();
        check_eq("pp_head",   out_data4,  8'hA2);
        check_eq("pp_occ",    occupancy4, 2'd1);
        in_valid4 = 4'b0000;
        step();
        check_eq("bp_empty",  out_valid4, 1'b0);
        check_eq("bp_occ_e",  occupancy4, 2'd0);

        // Legacy on 4 channels, fixed_sel=3; ready asserted even without valid.
        rr_en4 = 1'b0; fifo_en4 = 1'b1; dma_mode4 = 1'b1; fixed_sel4 = 2'd3;
        in_valid4 = 4'b0000; in_data4 = 32'hC3000000;
        #1;
        check_eq("leg4_ready_novalid", in_ready4, 4'b1000);
        step();
        check_eq("leg4_no_push", occupancy4, 2'd0);
        in_valid4 = 4'b1000;
        step();
        check_eq("leg4_out_ch",   out_ch4,   2'd3);
        check_eq("leg4_out_data", out_data4, 8'hC3);
        in_valid4 = 4'b0000;
        step();

        // Reset while full, then round-robin restarts at ch0.
        rr_en4 = 1'b1; out_ready4 = 1'b0; in_valid4 = 4'b0001; in_data4 = 32'h0000005A;
        step();
        step();
        check_eq("full_before_rst", occupancy4, 2'd2);
        reset = 1'b1;
        step();
        check_eq("rst_full_valid", out_valid4, 1'b0);
        check_eq("rst_full_occ",   occupancy4, 2'd0);
        check_eq("rst_full_data",  out_data4,  8'h00);
        check_eq("rst_full_ready", in_ready4,  4'b0000);
        reset = 1'b0;
        in_valid4 = 4'b1111; in_data4 = 32'hC3C2C1C0; out_ready4 = 1'b1;
        #1;
        check_eq("post_rst_ready", in_ready4, 4'b0001);
        step();
        check_eq("post_rst_ch",   out_ch4,   2'd0);
        check_eq("post_rst_data", out_data4, 8'hC0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
